// File: rtl/td4_pkg.sv
// Shared TD4 definitions: program ROM geometry and the loader state encoding.
// Optional feature macro: TD4_LOADER_CKSUM_EN adds the CHECK and ERR states.
package td4_pkg;

  localparam int ROM_DEPTH = 16;
  localparam int WORD_W    = 8;
  localparam int ADDR_W    = 4;

  // The loader state is visible on a debug port, so the encoding is fixed here.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2
`ifdef TD4_LOADER_CKSUM_EN
    ,
    ST_CHECK = 3'd3,
    ST_ERR   = 3'd4
`endif
  } loader_state_t;

endpackage

// File: rtl/td4_prog_ram.sv
// 16x8 program register file: one synchronous write port, one asynchronous
// read port, and every word cleared to zero by the asynchronous reset.
module td4_prog_ram
  import td4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [ROM_DEPTH];

  // Write port; reset clears the whole array so no stale program survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROM_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Zero-latency read so the CPU sees the instruction in the same cycle.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/td4_prog_loader.sv
// TD4 program loader: streams 16 program bytes into the program RAM while
// holding the CPU, then releases it. Optional macro TD4_LOADER_CKSUM_EN
// appends one checksum byte (sum of the 16 bytes modulo 256) that must match
// before the CPU is released; a mismatch parks the loader in ERR.
//
// Handshake: a byte transfers on a rising edge where ld_valid=1 and
// ld_ready=1. ld_ready depends on state only (LOAD or CHECK), never on
// ld_valid; ld_data is ignored in every other cycle. start wins over a
// coincident transfer: that byte is dropped and the load restarts at 0.
module td4_prog_loader
  import td4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ld_valid,
  input  logic [WORD_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [WORD_W-1:0] cpu_instr,
  output logic              cpu_hold,
  output logic              prog_done,
  output logic              err,
  output loader_state_t     dbg_state
);

  loader_state_t     r_state;
  loader_state_t     w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic              w_xfer;
  logic              w_we;
  logic              w_last;

  assign w_xfer = ld_valid && ld_ready;
  assign w_last = (r_ptr == ADDR_W'(ROM_DEPTH - 1));
  assign w_we   = (r_state == ST_LOAD) && w_xfer && !start;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Write pointer: cleared by start, advanced by each accepted LOAD byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_ptr <= '0;
    else if (start) r_ptr <= '0;
    else if (w_we)  r_ptr <= r_ptr + 1'b1;
  end

`ifdef TD4_LOADER_CKSUM_EN
  logic [WORD_W-1:0] r_acc;

  // Running modulo-256 sum of the bytes written during LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_acc <= '0;
    else if (start) r_acc <= '0;
    else if (w_we)  r_acc <= r_acc + ld_data;
  end
`endif

  // Next-state decode; start overrides everything, including a transfer.
  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_xfer && w_last) begin
`ifdef TD4_LOADER_CKSUM_EN
            w_next = ST_CHECK;
`else
            w_next = ST_RUN;
`endif
          end
        end
`ifdef TD4_LOADER_CKSUM_EN
        ST_CHECK: begin
          if (w_xfer) w_next = (ld_data == r_acc) ? ST_RUN : ST_ERR;
        end
`endif
        default: w_next = r_state;
      endcase
    end
  end

  // Outputs are decoded purely from the registered state.
  always_comb begin
    ld_ready  = (r_state == ST_LOAD);
`ifdef TD4_LOADER_CKSUM_EN
    ld_ready  = ld_ready || (r_state == ST_CHECK);
    err       = (r_state == ST_ERR);
`else
    err       = 1'b0;
`endif
    prog_done = (r_state == ST_RUN);
    cpu_hold  = (r_state != ST_RUN);
  end

  assign dbg_state = r_state;

  td4_prog_ram u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (r_ptr),
    .i_wdata (ld_data),
    .i_raddr (cpu_addr),
    .o_rdata (cpu_instr)
  );

endmodule
